// File: rtl/proc_sequencer_pkg.sv
// Shared constants for the program sequencer:
// opcode values, instruction field positions and FSM state codes.
package proc_sequencer_pkg;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_IMM   = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;

endpackage

// File: rtl/proc_sequencer_if.sv
// ROM and processor pin bundle of the sequencer.
// master = sequencer side, slave = ROM/processor side.
interface proc_sequencer_if #(
   parameter int AW = 5,
   parameter int DW = 16
);

   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemData;
   logic [DW-1:0] ProcDIN;
   logic          Run;
   logic          Done;

   modport master (
      output MemAddr,
      output ProcDIN,
      output Run,
      input  MemData,
      input  Done
   );

   modport slave (
      input  MemAddr,
      input  ProcDIN,
      input  Run,
      output MemData,
      output Done
   );

endinterface

// File: rtl/proc_sequencer_timeout_cnt.sv
// Loadable, clearable up-counter with a terminal-count flag.
// Clear has priority over load, load over increment.
module seq_timeout_cnt #(
   parameter int           W  = 4,
   parameter logic [W-1:0] TC = '1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/proc_sequencer.sv
// Program sequencer: fetches words from a synchronous ROM and
// paces the bus processor through its Run/Done handshake.
module proc_sequencer
   import proc_sequencer_pkg::*;
#(
   parameter int AW        = 5,
   parameter int DW        = 16,
   parameter int LAST_ADDR = 31,
   parameter int TIMEOUT   = 15
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          Start,
   input  logic          Stop,
   input  logic          Step,
   input  logic          Clear,
   proc_sequencer_if.master bus,
   output logic          Busy,
   output logic          Halted,
   output logic          Err,
   output logic [AW-1:0] PC
);

   localparam int           CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] instr_q, instr_d;
   logic [DW-1:0] imm_q, imm_d;
   logic          err_q, err_d;

   logic          is_mvi, is_halt;
   logic          last_hit;
   logic          tc, tmo;
   logic [AW-1:0] pc_m1;

   assign is_mvi  = instr_q[OPC_HI:OPC_LO] == OP_MVI;
   assign is_halt = instr_q[OPC_HI:OPC_LO] == OP_HALT;
   assign pc_m1   = pc_q - AW'(1);
   assign last_hit = pc_m1 == AW'(LAST_ADDR);
   assign tmo     = (state_q == S_WAIT) && tc;

   // counts only while waiting; any Done restarts the window
   seq_timeout_cnt #(
      .W  (CW),
      .TC (TC)
   ) u_tmo (
      .clk_i      (Clock),
      .rst_ni     (Resetn),
      .clr_i      ((state_q != S_WAIT) || bus.Done),
      .en_i       (state_q == S_WAIT),
      .load_i     (1'b0),
      .load_val_i ('0),
      .tc_o       (tc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      imm_d   = imm_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (Clear) begin
               pc_d  = '0;
               err_d = 1'b0;
            end else if (Start) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            instr_d = bus.MemData;
            pc_d    = pc_q + AW'(1);
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            unique case (1'b1)
               is_halt: begin
                  pc_d    = pc_m1;
                  state_d = S_HALT;
               end
               is_mvi:  state_d = S_IMM;
               default: state_d = S_WAIT;
            endcase
         end
         S_IMM: begin
            imm_d   = bus.MemData;
            pc_d    = pc_q + AW'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.Done) begin
               if (Stop || last_hit) begin
                  state_d = S_HALT;
               end else if (Step) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            if (Clear) begin
               pc_d  = '0;
               err_d = 1'b0;
            end else if (Start && !err_q) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         imm_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
         err_q   <= err_d;
      end
   end

   assign bus.MemAddr = pc_q;
   assign bus.Run     = (state_q == S_ISSUE) && !is_halt;

   // IMM is the processor's T1: the immediate goes straight through
   assign bus.ProcDIN =
      (state_q == S_IMM)           ? bus.MemData :
      (state_q == S_WAIT && is_mvi) ? imm_q       :
                                      instr_q;

   assign Busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                   (state_q == S_IMM)   || (state_q == S_WAIT);
   assign Halted = state_q == S_HALT;
   assign Err    = err_q;
   assign PC     = pc_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a ROM and a Done model.
// Outputs are sampled on the falling clock edge.
module tb_proc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       Start, Stop, Step, Clear;
   logic       Busy, Halted, Err;
   logic [4:0] PC;

   proc_sequencer_if #(.AW(5), .DW(16)) bus ();

   proc_sequencer #(
      .AW        (5),
      .DW        (16),
      .LAST_ADDR (31),
      .TIMEOUT   (15)
   ) dut (
      .Clock  (clk),
      .Resetn (rst_n),
      .Start  (Start),
      .Stop   (Stop),
      .Step   (Step),
      .Clear  (Clear),
      .bus    (bus),
      .Busy   (Busy),
      .Halted (Halted),
      .Err    (Err),
      .PC     (PC)
   );

   logic [15:0] rom [32];
   int          checks = 0;
   int          failures = 0;
   int          cyc, runs, consec;
   int          run_at [8];
   logic        prev_run;
   logic [15:0] din_after_run;
   int          quiet;
   bit          done_en;
   int          k;
   bit          pend;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_ff @(posedge clk) bus.MemData <= rom[bus.MemAddr];

   // processor: Done after 'quiet' silent cycles following Run
   always @(negedge clk) begin
      if (!rst_n) begin
         pend     <= 1'b0;
         k        <= 0;
         bus.Done <= 1'b0;
      end else if (bus.Run) begin
         pend     <= done_en;
         k        <= 1;
         bus.Done <= 1'b0;
      end else if (pend) begin
         if (k == quiet + 1) begin
            bus.Done <= 1'b1;
            pend     <= 1'b0;
         end else begin
            bus.Done <= 1'b0;
            k        <= k + 1;
         end
      end else begin
         bus.Done <= 1'b0;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (prev_run) din_after_run = bus.ProcDIN;
      if (bus.Run) begin
         if (prev_run) consec++;
         if (runs < 8) run_at[runs] = cyc;
         runs++;
      end
      prev_run = bus.Run;
   endtask

   task automatic do_reset();
      Start   = 0;
      Stop    = 0;
      Step    = 0;
      Clear   = 0;
      done_en = 0;
      quiet   = 3;
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1;
      runs     = 0;
      consec   = 0;
      prev_run = 0;
      cyc      = 0;
   endtask

   task automatic clr_rom();
      for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
   endtask

   initial begin
      rst_n = 0;
      Start = 0;
      Stop  = 0;
      Step  = 0;
      Clear = 0;
      done_en = 0;
      quiet = 3;
      runs = 0;
      consec = 0;
      cyc = 0;
      prev_run = 0;
      din_after_run = '0;
      clr_rom();

      // reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_addr", bus.MemAddr, 0);
      chk("rst_din", bus.ProcDIN, 0);
      chk("rst_run", bus.Run, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_halt", Halted, 0);
      chk("rst_err", Err, 0);
      chk("rst_pc", PC, 0);

      // mv, add, halt
      rom[0] = 16'h0040;
      rom[1] = 16'h4080;
      rom[2] = 16'hE000;
      do_reset();
      done_en = 1;
      Start = 1;
      step();
      Start = 0;
      chk("t1_fetch_busy", Busy, 1);
      chk("t1_fetch_addr", bus.MemAddr, 0);
      step();
      chk("t1_run", bus.Run, 1);
      chk("t1_din", bus.ProcDIN, 16'h0040);
      chk("t1_pc", PC, 1);
      repeat (13) step();
      chk("t1_halted", Halted, 1);
      chk("t1_pc_halt", PC, 2);
      chk("t1_err", Err, 0);
      chk("t1_busy", Busy, 0);
      chk("t1_runs", runs, 2);
      chk("t1_run0", run_at[0], 2);
      chk("t1_run1", run_at[1], 8);

      // mvi with immediate
      clr_rom();
      rom[0] = 16'h2000;
      rom[1] = 16'h00A5;
      rom[2] = 16'h4080;
      rom[3] = 16'hE000;
      do_reset();
      done_en = 1;
      Start = 1;
      step();
      Start = 0;
      step();
      chk("t2_run", bus.Run, 1);
      step();
      chk("t2_imm_din", bus.ProcDIN, 16'h00A5);
      chk("t2_imm_run", bus.Run, 0);
      step();
      chk("t2_wait_din", bus.ProcDIN, 16'h00A5);
      chk("t2_wait_pc", PC, 2);
      repeat (3) step();
      chk("t2_fetch_addr", bus.MemAddr, 2);
      step();
      chk("t2_run2", bus.Run, 1);
      chk("t2_din2", bus.ProcDIN, 16'h4080);
      repeat (7) step();
      chk("t2_halted", Halted, 1);
      chk("t2_pc", PC, 3);

      // Done never arrives
      clr_rom();
      rom[0] = 16'h4080;
      do_reset();
      done_en = 0;
      Start = 1;
      step();
      Start = 0;
      repeat (16) step();
      chk("t3_err_early", Err, 0);
      chk("t3_busy_early", Busy, 1);
      step();
      chk("t3_err", Err, 1);
      chk("t3_halted", Halted, 1);
      chk("t3_busy", Busy, 0);
      Start = 1;
      step();
      step();
      chk("t3_start_ign", Halted, 1);
      Clear = 1;
      step();
      chk("t3_clr_halt", Halted, 1);
      chk("t3_clr_err", Err, 0);
      chk("t3_clr_pc", PC, 0);
      Clear = 0;
      step();
      Start = 0;
      chk("t3_refetch", Busy, 1);
      chk("t3_refetch_addr", bus.MemAddr, 0);
      step();
      chk("t3_rerun", bus.Run, 1);
      chk("t3_rerun_din", bus.ProcDIN, 16'h4080);

      // single step, then Stop
      clr_rom();
      rom[0] = 16'h0040;
      rom[1] = 16'h4080;
      rom[2] = 16'h6080;
      rom[3] = 16'h6080;
      rom[4] = 16'hE000;
      do_reset();
      done_en = 1;
      quiet = 1;
      Step = 1;
      for (int j = 0; j < 3; j++) begin
         Start = 1;
         step();
         Start = 0;
         repeat (5) step();
         chk("t4_runs", runs, j + 1);
         chk("t4_idle_busy", Busy, 0);
         chk("t4_idle_halt", Halted, 0);
         chk("t4_pc", PC, j + 1);
      end
      Step = 0;
      Stop = 1;
      Start = 1;
      step();
      Start = 0;
      repeat (5) step();
      Stop = 0;
      chk("t4_stop_halt", Halted, 1);
      chk("t4_stop_pc", PC, 4);
      chk("t4_stop_runs", runs, 4);
      chk("t4_consec", consec, 0);

      // mvi at 30, immediate at 31, PC wraps
      clr_rom();
      for (int i = 0; i < 30; i++) rom[i] = 16'h0040;
      rom[30] = 16'h2000;
      rom[31] = 16'h1234;
      do_reset();
      done_en = 1;
      quiet = 1;
      Start = 1;
      step();
      Start = 0;
      for (int i = 0; i < 200 && !Halted; i++) step();
      chk("t5_halted", Halted, 1);
      chk("t5_pc", PC, 0);
      chk("t5_runs", runs, 31);
      chk("t5_imm", din_after_run, 16'h1234);
      chk("t5_err", Err, 0);
      chk("t5_consec", consec, 0);

      // reset during IMM
      clr_rom();
      rom[0] = 16'h2000;
      rom[1] = 16'h00A5;
      rom[2] = 16'hE000;
      do_reset();
      done_en = 1;
      Start = 1;
      step();
      Start = 0;
      step();
      step();
      chk("t6_in_imm", bus.ProcDIN, 16'h00A5);
      rst_n = 0;
      #1;
      chk("t6_addr", bus.MemAddr, 0);
      chk("t6_din", bus.ProcDIN, 0);
      chk("t6_run", bus.Run, 0);
      chk("t6_busy", Busy, 0);
      chk("t6_halt", Halted, 0);
      chk("t6_err", Err, 0);
      chk("t6_pc", PC, 0);
      step();
      rst_n = 1;
      Start = 1;
      step();
      Start = 0;
      chk("t6_fetch_addr", bus.MemAddr, 0);
      chk("t6_fetch_busy", Busy, 1);
      step();
      chk("t6_run2", bus.Run, 1);
      chk("t6_din2", bus.ProcDIN, 16'h2000);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
